// File: rtl/speriph_plug_arbiter.sv
// N-to-1 peripheral plug combiner: fixed-priority or round-robin arbitration,
// in-order response routing through an index FIFO, outstanding backpressure, sticky error.
module speriph_plug_arbiter #(
   parameter int NB_PLUGS   = 2,
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int ID_WIDTH   = 5,
   parameter int RESP_DEPTH = 2,
   parameter int ARB_MODE   = 1
) (
   input  logic                                   clk_i,
   input  logic                                   rst_ni,
   input  logic [NB_PLUGS-1:0]                    plug_req_i,
   input  logic [NB_PLUGS-1:0][ADDR_WIDTH-1:0]    plug_add_i,
   input  logic [NB_PLUGS-1:0]                    plug_wen_i,
   input  logic [NB_PLUGS-1:0][DATA_WIDTH-1:0]    plug_wdata_i,
   input  logic [NB_PLUGS-1:0][DATA_WIDTH/8-1:0]  plug_be_i,
   input  logic [NB_PLUGS-1:0][ID_WIDTH-1:0]      plug_id_i,
   output logic [NB_PLUGS-1:0]                    plug_gnt_o,
   output logic [NB_PLUGS-1:0]                    plug_r_valid_o,
   output logic                                   plug_r_opc_o,
   output logic [ID_WIDTH-1:0]                    plug_r_id_o,
   output logic [DATA_WIDTH-1:0]                  plug_r_rdata_o,
   output logic                                   slv_req_o,
   output logic [ADDR_WIDTH-1:0]                  slv_add_o,
   output logic                                   slv_wen_o,
   output logic [DATA_WIDTH-1:0]                  slv_wdata_o,
   output logic [DATA_WIDTH/8-1:0]                slv_be_o,
   output logic [ID_WIDTH-1:0]                    slv_id_o,
   input  logic                                   slv_gnt_i,
   input  logic                                   slv_r_valid_i,
   input  logic                                   slv_r_opc_i,
   input  logic [ID_WIDTH-1:0]                    slv_r_id_i,
   input  logic [DATA_WIDTH-1:0]                  slv_r_rdata_i,
   output logic [$clog2(RESP_DEPTH+1)-1:0]        outstanding_o,
   output logic                                   err_o
);
   localparam int PW = $clog2(NB_PLUGS);
   localparam int FW = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
   localparam int CW = $clog2(RESP_DEPTH+1);
   localparam logic [FW-1:0] F_LAST = FW'(RESP_DEPTH-1);
   localparam logic [PW-1:0] P_LAST = PW'(NB_PLUGS-1);
   localparam logic [CW-1:0] C_FULL = CW'(RESP_DEPTH);

   logic [PW-1:0] r_rr_ptr;
   logic [PW-1:0] r_fifo [RESP_DEPTH];
   logic [FW-1:0] r_wr, r_rd;
   logic [CW-1:0] r_count;
   logic          r_err;

   logic [PW-1:0] w_win, w_sel;
   int            w_base, w_k;
   logic          w_full, w_empty, w_push, w_pop;

   // Walk candidates from farthest to nearest so the last hit is the first
   // requester at or after the base index (base 0 gives fixed priority).
   always_comb begin
      w_win  = '0;
      w_k    = 0;
      w_base = (ARB_MODE == 1) ? int'(r_rr_ptr) : 0;
      for (int i = NB_PLUGS-1; i >= 0; i--) begin
         w_k = w_base + i;
         if (w_k >= NB_PLUGS) w_k = w_k - NB_PLUGS;
         if (plug_req_i[PW'(w_k)]) w_win = PW'(w_k);
      end
   end

   assign w_full    = (r_count == C_FULL);
   assign w_empty   = (r_count == '0);
   assign slv_req_o = (|plug_req_i) & ~w_full;
   assign w_push    = slv_req_o & slv_gnt_i;
   assign w_pop     = slv_r_valid_i & ~w_empty;
   assign w_sel     = slv_req_o ? w_win : '0;

   assign slv_add_o   = plug_add_i[w_sel];
   assign slv_wen_o   = plug_wen_i[w_sel];
   assign slv_wdata_o = plug_wdata_i[w_sel];
   assign slv_be_o    = plug_be_i[w_sel];
   assign slv_id_o    = plug_id_i[w_sel];

   always_comb begin
      plug_gnt_o     = '0;
      plug_r_valid_o = '0;
      if (w_push) plug_gnt_o[w_win] = 1'b1;
      if (w_pop)  plug_r_valid_o[r_fifo[r_rd]] = 1'b1;
   end

   assign plug_r_opc_o   = slv_r_opc_i;
   assign plug_r_id_o    = slv_r_id_i;
   assign plug_r_rdata_o = slv_r_rdata_i;
   assign outstanding_o  = r_count;
   assign err_o          = r_err;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_rr_ptr <= '0;
         r_wr     <= '0;
         r_rd     <= '0;
         r_count  <= '0;
         r_err    <= 1'b0;
         for (int i = 0; i < RESP_DEPTH; i++) r_fifo[i] <= '0;
      end else begin
         if (w_push) begin
            r_fifo[r_wr] <= w_win;
            r_wr         <= (r_wr == F_LAST) ? '0 : r_wr + 1'b1;
            if (ARB_MODE == 1) r_rr_ptr <= (w_win == P_LAST) ? '0 : w_win + 1'b1;
         end
         if (w_pop) r_rd <= (r_rd == F_LAST) ? '0 : r_rd + 1'b1;
         if (w_push && !w_pop)      r_count <= r_count + 1'b1;
         else if (!w_push && w_pop) r_count <= r_count - 1'b1;
         if (slv_r_valid_i && w_empty) r_err <= 1'b1;
      end
   end
endmodule

// File: tb/tb_speriph_plug_arbiter.sv
// Bench for speriph_plug_arbiter: a fixed-priority and a round-robin instance share
// stimulus and are compared against a queue-based reference model.
module tb_speriph_plug_arbiter;
   localparam int N = 4, AW = 32, DW = 32, BW = 4, IW = 5, RD = 2, CW = $clog2(RD+1);

   logic clk = 1'b0, rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [N-1:0]         req, wen;
   logic [N-1:0][AW-1:0] add;
   logic [N-1:0][DW-1:0] wdata;
   logic [N-1:0][BW-1:0] be;
   logic [N-1:0][IW-1:0] id;
   logic                 sgnt, srv, sopc;
   logic [IW-1:0]        srid;
   logic [DW-1:0]        srdata;

   logic [N-1:0]  gnt [2];
   logic [N-1:0]  rvld [2];
   logic          ropc [2];
   logic [IW-1:0] rid [2];
   logic [DW-1:0] rdata [2];
   logic          sreq [2];
   logic [AW-1:0] sadd [2];
   logic          swen [2];
   logic [DW-1:0] swdata [2];
   logic [BW-1:0] sbe [2];
   logic [IW-1:0] sid [2];
   logic [CW-1:0] outs [2];
   logic          err [2];

   for (genvar m = 0; m < 2; m++) begin : g_dut
      speriph_plug_arbiter #(.NB_PLUGS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW),
                             .RESP_DEPTH(RD), .ARB_MODE(m)) u_dut (
         .clk_i(clk), .rst_ni(rst_n),
         .plug_req_i(req), .plug_add_i(add), .plug_wen_i(wen), .plug_wdata_i(wdata),
         .plug_be_i(be), .plug_id_i(id),
         .plug_gnt_o(gnt[m]), .plug_r_valid_o(rvld[m]), .plug_r_opc_o(ropc[m]),
         .plug_r_id_o(rid[m]), .plug_r_rdata_o(rdata[m]),
         .slv_req_o(sreq[m]), .slv_add_o(sadd[m]), .slv_wen_o(swen[m]),
         .slv_wdata_o(swdata[m]), .slv_be_o(sbe[m]), .slv_id_o(sid[m]),
         .slv_gnt_i(sgnt), .slv_r_valid_i(srv), .slv_r_opc_i(sopc),
         .slv_r_id_i(srid), .slv_r_rdata_i(srdata),
         .outstanding_o(outs[m]), .err_o(err[m]));
   end

   // Reference model: pending plug indices in grant order, rotation pointer, error flag.
   int rr [2];
   int q0 [$];
   int q1 [$];
   bit merr [2];
   int tests = 0, fails = 0;

   task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic int qsize(int m);
      return (m == 0) ? q0.size() : q1.size();
   endfunction

   function automatic int qhead(int m);
      if (qsize(m) == 0) return 0;
      return (m == 0) ? q0[0] : q1[0];
   endfunction

   function automatic int win_of(int m);
      for (int i = 0; i < N; i++) begin
         int k = (m == 0) ? i : (rr[m] + i) % N;
         if (req[k]) return k;
      end
      return 0;
   endfunction

   task automatic model_check(int m);
      int  w  = win_of(m);
      int  sz = qsize(m);
      bit  r  = (req != 0) && (sz < RD);
      chk($sformatf("slv_req[m%0d]", m), 64'(sreq[m]), 64'(r));
      chk($sformatf("gnt[m%0d]", m), 64'(gnt[m]), (sgnt && r) ? 64'(1) << w : 64'(0));
      if (r) begin
         chk($sformatf("slv_add[m%0d]", m), 64'(sadd[m]), 64'(add[w]));
         chk($sformatf("slv_wen[m%0d]", m), 64'(swen[m]), 64'(wen[w]));
         chk($sformatf("slv_wdata[m%0d]", m), 64'(swdata[m]), 64'(wdata[w]));
         chk($sformatf("slv_be[m%0d]", m), 64'(sbe[m]), 64'(be[w]));
         chk($sformatf("slv_id[m%0d]", m), 64'(sid[m]), 64'(id[w]));
      end
      chk($sformatf("r_valid[m%0d]", m), 64'(rvld[m]),
          (srv && sz > 0) ? 64'(1) << qhead(m) : 64'(0));
      chk($sformatf("r_opc[m%0d]", m), 64'(ropc[m]), 64'(sopc));
      chk($sformatf("r_id[m%0d]", m), 64'(rid[m]), 64'(srid));
      chk($sformatf("r_rdata[m%0d]", m), 64'(rdata[m]), 64'(srdata));
      chk($sformatf("outstanding[m%0d]", m), 64'(outs[m]), 64'(sz));
      chk($sformatf("err[m%0d]", m), 64'(err[m]), 64'(merr[m]));
   endtask

   task automatic model_update(int m);
      int  w  = win_of(m);
      int  sz = qsize(m);
      bit  push = (req != 0) && (sz < RD) && sgnt;
      if (srv && sz == 0) merr[m] = 1'b1;
      if (srv && sz > 0) begin
         if (m == 0) void'(q0.pop_front()); else void'(q1.pop_front());
      end
      if (push) begin
         if (m == 0) q0.push_back(w); else q1.push_back(w);
         if (m == 1) rr[1] = (w + 1) % N;
      end
   endtask

   task automatic half_check();
      @(negedge clk);
      model_check(0);
      model_check(1);
   endtask

   task automatic half_update();
      @(posedge clk);
      model_update(0);
      model_update(1);
      #1;
   endtask

   task automatic step();
      half_check();
      half_update();
   endtask

   task automatic idle();
      req = '0; wen = '0; add = '0; wdata = '0; be = '0; id = '0;
      sgnt = 1'b0; srv = 1'b0; sopc = 1'b0; srid = '0; srdata = '0;
   endtask

   task automatic model_reset();
      rr[0] = 0; rr[1] = 0; merr[0] = 1'b0; merr[1] = 1'b0;
      q0.delete(); q1.delete();
   endtask

   // Entered and left at posedge+1; the edge inside reset sees idle inputs.
   task automatic do_reset();
      idle();
      rst_n = 1'b0;
      model_reset();
      #2;
      for (int m = 0; m < 2; m++) begin
         chk("rst_outstanding", 64'(outs[m]), 64'(0));
         chk("rst_err", 64'(err[m]), 64'(0));
         chk("rst_slv_req", 64'(sreq[m]), 64'(0));
         chk("rst_gnt", 64'(gnt[m]), 64'(0));
         chk("rst_rvalid", 64'(rvld[m]), 64'(0));
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic randomize_fields();
      for (int p = 0; p < N; p++) begin
         add[p] = $urandom; wdata[p] = $urandom;
         be[p] = BW'($urandom); id[p] = IW'($urandom);
      end
      wen = N'($urandom);
      sopc = 1'($urandom); srid = IW'($urandom); srdata = $urandom;
   endtask

   typedef struct {
      logic [N-1:0] req;
      logic         gnt;
      logic         rv;
      logic [N-1:0] eg1, erv1, eg0, erv0;
   } vec_t;
   vec_t tbl [9];

   initial begin
      // All plugs requesting, slave always grants, response one cycle later.
      tbl[0] = '{4'hF, 1'b1, 1'b0, 4'h1, 4'h0, 4'h1, 4'h0};
      tbl[1] = '{4'hF, 1'b1, 1'b1, 4'h2, 4'h1, 4'h1, 4'h1};
      tbl[2] = '{4'hF, 1'b1, 1'b1, 4'h4, 4'h2, 4'h1, 4'h1};
      tbl[3] = '{4'hF, 1'b1, 1'b1, 4'h8, 4'h4, 4'h1, 4'h1};
      tbl[4] = '{4'hF, 1'b1, 1'b1, 4'h1, 4'h8, 4'h1, 4'h1};
      tbl[5] = '{4'hF, 1'b1, 1'b1, 4'h2, 4'h1, 4'h1, 4'h1};
      tbl[6] = '{4'hF, 1'b1, 1'b1, 4'h4, 4'h2, 4'h1, 4'h1};
      tbl[7] = '{4'hF, 1'b1, 1'b1, 4'h8, 4'h4, 4'h1, 4'h1};
      tbl[8] = '{4'h0, 1'b0, 1'b1, 4'h0, 4'h8, 4'h0, 4'h1};

      idle();
      model_reset();
      #12;
      @(posedge clk); #1;
      do_reset();

      for (int i = 0; i < 9; i++) begin
         randomize_fields();
         req = tbl[i].req; sgnt = tbl[i].gnt; srv = tbl[i].rv;
         half_check();
         chk($sformatf("tbl%0d_gnt_rr", i), 64'(gnt[1]), 64'(tbl[i].eg1));
         chk($sformatf("tbl%0d_rv_rr", i), 64'(rvld[1]), 64'(tbl[i].erv1));
         chk($sformatf("tbl%0d_gnt_fp", i), 64'(gnt[0]), 64'(tbl[i].eg0));
         chk($sformatf("tbl%0d_rv_fp", i), 64'(rvld[0]), 64'(tbl[i].erv0));
         half_update();
      end

      // Fixed priority: plugs 1 and 3 compete, 1 always wins until it drops.
      do_reset();
      req = 4'b1010; sgnt = 1'b1;
      for (int i = 0; i < 5; i++) begin
         srv = (i > 0);
         half_check();
         chk("fp_plug1_wins", 64'(gnt[0]), 64'h2);
         half_update();
      end
      req = 4'b1000;
      half_check();
      chk("fp_plug3_after_drop", 64'(gnt[0]), 64'h8);
      half_update();
      req = '0; step();

      // Backpressure: responses withheld until the FIFO fills.
      do_reset();
      req = 4'b0010; sgnt = 1'b1; srv = 1'b0;
      step(); step();
      half_check();
      chk("bp_full_req", 64'(sreq[0]), 64'(0));
      chk("bp_full_outs", 64'(outs[1]), 64'(2));
      half_update();
      srv = 1'b1;
      half_check();
      chk("bp_release_rv", 64'(rvld[1]), 64'h2);
      chk("bp_no_push_on_full", 64'(gnt[1]), 64'h0);
      half_update();
      srv = 1'b0;
      half_check();
      chk("bp_next_grant", 64'(gnt[1]), 64'h2);
      half_update();
      req = '0; srv = 1'b1; step(); step(); srv = 1'b0;

      // Variable-latency routing: plug 2 then plug 0, responses at +3 and +4.
      do_reset();
      sgnt = 1'b1; wen = 4'b0101;
      req = 4'b0100; step();
      req = 4'b0001; step();
      req = '0; step();
      srv = 1'b1; srid = 5'h5;
      half_check();
      chk("route_first_rv", 64'(rvld[1]), 64'h4);
      chk("route_first_id", 64'(rid[1]), 64'h5);
      half_update();
      srid = 5'h9;
      half_check();
      chk("route_second_rv", 64'(rvld[0]), 64'h1);
      chk("route_second_id", 64'(rid[0]), 64'h9);
      half_update();
      srv = 1'b0;

      // Spurious response with an empty FIFO.
      srv = 1'b1;
      half_check();
      chk("spur_no_rv", 64'(rvld[0] | rvld[1]), 64'h0);
      half_update();
      srv = 1'b0;
      for (int i = 0; i < 3; i++) begin
         half_check();
         chk("spur_err_sticky", 64'(err[1]), 64'h1);
         half_update();
      end

      // Mid-operation reset with a live rotation pointer and one outstanding entry.
      do_reset();
      sgnt = 1'b1; req = 4'b0100; step();
      req = '0; step();
      do_reset();
      sgnt = 1'b1; req = 4'hF;
      half_check();
      chk("rst_rr_ptr_zero", 64'(gnt[1]), 64'h1);
      half_update();
      req = '0; srv = 1'b1; step(); step();
      srv = 1'b0;
      half_check();
      chk("late_rv_err", 64'(err[0]), 64'h1);
      half_update();

      // Randomized traffic; responses only while something is outstanding.
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         randomize_fields();
         req  = N'($urandom);
         sgnt = ($urandom_range(0, 3) != 0);
         srv  = (q0.size() > 0) ? 1'($urandom) : 1'b0;
         step();
      end
      idle(); srv = 1'b1;
      for (int i = 0; i < 4; i++) step();
      idle();
      step();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: bench did not finish");
      $fatal(1);
   end
endmodule
